pipe_controller: RTL and testbench

Sequencing controller for the five-stage MIPS pipeline datapath. Decodes the ID-stage opcode/func into the nine per-instruction control signals. Resolves branches and jumps in ID (PC select plus IF/ID flush), and delays link-related controls so they reach the EX and WB stages aligned with their instruction. Also owns the start-up flush and the halt/drain sequence, since the pipeline registers have no reset of their own.

---
 rtl/pipe_controller_pkg.sv | 63 ++++++
 rtl/pipe_controller_if.sv | 42 ++++
 rtl/pipe_decoder.sv | 83 ++++++++
 rtl/pipe_controller.sv | 120 ++++++++++++
 tb/tb_pipe_controller.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/pipe_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_controller_pkg
// Brief    : Shared opcode/func codes, ALU codes, FSM encoding and control
//            bundle for the pipeline controller. Macro: PIPE_CTRL_LINK_EN.
// Revision : 1.0 - initial release
// ============================================================================
package pipe_controller_pkg;

    localparam logic [5:0] C_OP_RTYPE = 6'b000000;
    localparam logic [5:0] C_OP_J     = 6'b000010;
    localparam logic [5:0] C_OP_JAL   = 6'b000011;
    localparam logic [5:0] C_OP_BEQ   = 6'b000100;
    localparam logic [5:0] C_OP_BNE   = 6'b000101;
    localparam logic [5:0] C_OP_ADDI  = 6'b001000;
    localparam logic [5:0] C_OP_SLTI  = 6'b001010;
    localparam logic [5:0] C_OP_LW    = 6'b100011;
    localparam logic [5:0] C_OP_SW    = 6'b101011;
    localparam logic [5:0] C_OP_HALT  = 6'b111111;

    localparam logic [5:0] C_FN_JR    = 6'b001000;
    localparam logic [5:0] C_FN_ADD   = 6'b100000;
    localparam logic [5:0] C_FN_SUB   = 6'b100010;
    localparam logic [5:0] C_FN_AND   = 6'b100100;
    localparam logic [5:0] C_FN_OR    = 6'b100101;
    localparam logic [5:0] C_FN_SLT   = 6'b101010;

    localparam logic [2:0] C_ALU_AND  = 3'b000;
    localparam logic [2:0] C_ALU_OR   = 3'b001;
    localparam logic [2:0] C_ALU_ADD  = 3'b010;
    localparam logic [2:0] C_ALU_SUB  = 3'b110;
    localparam logic [2:0] C_ALU_SLT  = 3'b111;

    localparam logic [1:0] C_JSEL_BRANCH = 2'b00;
    localparam logic [1:0] C_JSEL_JUMP   = 2'b01;
    localparam logic [1:0] C_JSEL_RS     = 2'b10;

    localparam logic [2:0] C_ST_RESET = 3'd0;
    localparam logic [2:0] C_ST_FLUSH = 3'd1;
    localparam logic [2:0] C_ST_RUN   = 3'd2;
    localparam logic [2:0] C_ST_DRAIN = 3'd3;
    localparam logic [2:0] C_ST_HALT  = 3'd4;

    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic [2:0] alu_op;
        logic       pc_src;
        logic [1:0] jsel;
        logic       clr;
`ifdef PIPE_CTRL_LINK_EN
        logic       jal;
`endif
    } ctrl_t;

    localparam ctrl_t C_CTRL_NOP = '0;

endpackage
`default_nettype wire

// File: rtl/pipe_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_controller_if
// Brief    : ID-stage inputs and pipeline control outputs of the controller.
// Revision : 1.0 - initial release
// ============================================================================
interface pipe_controller_if;

    logic [5:0] opcode;
    logic [5:0] func;
    logic       eq;
    logic       id_stall;

    logic       PCinit;
    logic       PCsrc;
    logic [1:0] jsel;
    logic       clr;
    logic       RegDst;
    logic       ALUsrc;
    logic       MemRead;
    logic       MemWrite;
    logic       MemtoReg;
    logic       RegWrite;
    logic [2:0] ALUoperation;
    logic       jal;
    logic       jal_write;
    logic       halted;

    modport master (
        input  opcode, func, eq, id_stall,
        output PCinit, PCsrc, jsel, clr, RegDst, ALUsrc, MemRead, MemWrite,
               MemtoReg, RegWrite, ALUoperation, jal, jal_write, halted
    );

    modport slave (
        output opcode, func, eq, id_stall,
        input  PCinit, PCsrc, jsel, clr, RegDst, ALUsrc, MemRead, MemWrite,
               MemtoReg, RegWrite, ALUoperation, jal, jal_write, halted
    );

endinterface
`default_nettype wire

// File: rtl/pipe_decoder.sv
`default_nettype none
// ============================================================================
// Module   : pipe_decoder
// Brief    : Combinational ID-stage decode of opcode/func/eq into controls
//            and redirect. jal/jr decode only with PIPE_CTRL_LINK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_decoder
    import pipe_controller_pkg::*;
(
    input  wire logic [5:0] i_opcode,
    input  wire logic [5:0] i_func,
    input  wire logic       i_eq,
    output ctrl_t           o_ctrl
);

    always_comb begin
        o_ctrl = C_CTRL_NOP;
        case (i_opcode)
            C_OP_RTYPE: begin
                case (i_func)
                    C_FN_ADD: begin o_ctrl.reg_write = 1'b1; o_ctrl.alu_op = C_ALU_ADD; end
                    C_FN_SUB: begin o_ctrl.reg_write = 1'b1; o_ctrl.alu_op = C_ALU_SUB; end
                    C_FN_AND: begin o_ctrl.reg_write = 1'b1; o_ctrl.alu_op = C_ALU_AND; end
                    C_FN_OR:  begin o_ctrl.reg_write = 1'b1; o_ctrl.alu_op = C_ALU_OR;  end
                    C_FN_SLT: begin o_ctrl.reg_write = 1'b1; o_ctrl.alu_op = C_ALU_SLT; end
`ifdef PIPE_CTRL_LINK_EN
                    C_FN_JR: begin
                        o_ctrl.pc_src = 1'b1;
                        o_ctrl.jsel   = C_JSEL_RS;
                        o_ctrl.clr    = 1'b1;
                    end
`endif
                    default: o_ctrl = C_CTRL_NOP;
                endcase
            end
            C_OP_ADDI, C_OP_SLTI: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.reg_dst   = 1'b1;
                o_ctrl.alu_src   = 1'b1;
                o_ctrl.alu_op    = (i_opcode == C_OP_ADDI) ? C_ALU_ADD : C_ALU_SLT;
            end
            C_OP_LW: begin
                o_ctrl.mem_read   = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.reg_dst    = 1'b1;
                o_ctrl.alu_src    = 1'b1;
                o_ctrl.alu_op     = C_ALU_ADD;
            end
            C_OP_SW: begin
                o_ctrl.mem_write = 1'b1;
                o_ctrl.alu_src   = 1'b1;
                o_ctrl.alu_op    = C_ALU_ADD;
            end
            C_OP_BEQ, C_OP_BNE: begin
                // beq takes on eq=1, bne on eq=0
                if (i_eq == (i_opcode == C_OP_BEQ)) begin
                    o_ctrl.pc_src = 1'b1;
                    o_ctrl.jsel   = C_JSEL_BRANCH;
                    o_ctrl.clr    = 1'b1;
                end
            end
            C_OP_J: begin
                o_ctrl.pc_src = 1'b1;
                o_ctrl.jsel   = C_JSEL_JUMP;
                o_ctrl.clr    = 1'b1;
            end
`ifdef PIPE_CTRL_LINK_EN
            C_OP_JAL: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.pc_src    = 1'b1;
                o_ctrl.jsel      = C_JSEL_JUMP;
                o_ctrl.clr       = 1'b1;
                o_ctrl.jal       = 1'b1;
            end
`endif
            default: o_ctrl = C_CTRL_NOP;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/pipe_controller.sv
`default_nettype none
// ============================================================================
// Module   : pipe_controller
// Brief    : Pipeline sequencing FSM (reset/flush/run/drain/halt), stall
//            gating and jal delay line. Macro: PIPE_CTRL_LINK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_controller
    import pipe_controller_pkg::*;
#(
    parameter int FLUSH_CYCLES = 4,
    parameter int DRAIN_CYCLES = 3
) (
    input  wire logic          clk,
    input  wire logic          init,
    pipe_controller_if.master  bus
);

    localparam int C_CNT_MAX = (FLUSH_CYCLES > DRAIN_CYCLES) ? FLUSH_CYCLES : DRAIN_CYCLES;
    localparam int C_CNT_W   = (C_CNT_MAX > 2) ? $clog2(C_CNT_MAX) : 1;
    localparam logic [C_CNT_W-1:0] C_CNT_ONE   = 1;
    localparam logic [C_CNT_W-1:0] C_CNT_FLUSH = C_CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [C_CNT_W-1:0] C_CNT_DRAIN = C_CNT_W'(DRAIN_CYCLES - 1);

    logic [2:0]         r_state;
    logic [C_CNT_W-1:0] r_cnt;
    ctrl_t              w_dec;
    ctrl_t              w_ctrl;
    logic               w_pcinit;
    logic               w_halted;

    pipe_decoder u_decoder (
        .i_opcode (bus.opcode),
        .i_func   (bus.func),
        .i_eq     (bus.eq),
        .o_ctrl   (w_dec)
    );

    always_ff @(posedge clk) begin
        if (init) begin
            r_state <= C_ST_RESET;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                C_ST_RESET: begin
                    r_state <= C_ST_FLUSH;
                    r_cnt   <= C_CNT_FLUSH;
                end
                C_ST_FLUSH: begin
                    if (r_cnt == '0) r_state <= C_ST_RUN;
                    else             r_cnt   <= r_cnt - C_CNT_ONE;
                end
                C_ST_RUN: begin
                    // A stalled halt is retried once the stall clears
                    if (bus.opcode == C_OP_HALT && !bus.id_stall) begin
                        r_state <= C_ST_DRAIN;
                        r_cnt   <= C_CNT_DRAIN;
                    end
                end
                C_ST_DRAIN: begin
                    if (r_cnt == '0) r_state <= C_ST_HALT;
                    else             r_cnt   <= r_cnt - C_CNT_ONE;
                end
                C_ST_HALT: r_state <= C_ST_HALT;
                default:   r_state <= C_ST_RESET;
            endcase
        end
    end

    always_comb begin
        w_ctrl     = C_CTRL_NOP;
        w_ctrl.clr = 1'b1;
        w_pcinit   = 1'b0;
        w_halted   = 1'b0;
        case (r_state)
            C_ST_RUN: begin
                // Stall must not let a waiting branch flush its own slot
                w_ctrl        = w_dec;
                w_ctrl.pc_src = w_dec.pc_src & ~bus.id_stall;
                w_ctrl.clr    = w_dec.clr & ~bus.id_stall;
`ifdef PIPE_CTRL_LINK_EN
                w_ctrl.jal    = w_dec.jal & ~bus.id_stall;
`endif
            end
            C_ST_FLUSH, C_ST_DRAIN: ;
            C_ST_HALT: w_halted = 1'b1;
            default:   w_pcinit = 1'b1;
        endcase
    end

`ifdef PIPE_CTRL_LINK_EN
    logic [2:0] r_link;

    always_ff @(posedge clk) begin
        if (init) r_link <= '0;
        else      r_link <= {r_link[1:0], w_ctrl.jal};
    end

    assign bus.jal       = r_link[0];
    assign bus.jal_write = r_link[2];
`else
    assign bus.jal       = 1'b0;
    assign bus.jal_write = 1'b0;
`endif

    assign bus.PCinit       = w_pcinit;
    assign bus.PCsrc        = w_ctrl.pc_src;
    assign bus.jsel         = w_ctrl.jsel;
    assign bus.clr          = w_ctrl.clr;
    assign bus.RegDst       = w_ctrl.reg_dst;
    assign bus.ALUsrc       = w_ctrl.alu_src;
    assign bus.MemRead      = w_ctrl.mem_read;
    assign bus.MemWrite     = w_ctrl.mem_write;
    assign bus.MemtoReg     = w_ctrl.mem_to_reg;
    assign bus.RegWrite     = w_ctrl.reg_write;
    assign bus.ALUoperation = w_ctrl.alu_op;
    assign bus.halted       = w_halted;

endmodule
`default_nettype wire

// File: tb/tb_pipe_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_controller
// Brief    : Directed scoreboard bench for pipe_controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_controller;

    // Output vector: {PCinit, PCsrc, jsel[1:0], clr, RegDst, ALUsrc, MemRead,
    //                 MemWrite, MemtoReg, RegWrite, ALUop[2:0], jal, jal_write, halted}
    localparam logic [16:0] E_PCINIT = 17'h10000;
    localparam logic [16:0] E_PCSRC  = 17'h08000;
    localparam logic [16:0] E_J10    = 17'h04000;
    localparam logic [16:0] E_J01    = 17'h02000;
    localparam logic [16:0] E_CLR    = 17'h01000;
    localparam logic [16:0] E_RD     = 17'h00800;
    localparam logic [16:0] E_AS     = 17'h00400;
    localparam logic [16:0] E_MR     = 17'h00200;
    localparam logic [16:0] E_MW     = 17'h00100;
    localparam logic [16:0] E_M2R    = 17'h00080;
    localparam logic [16:0] E_RW     = 17'h00040;
    localparam logic [16:0] A_OR     = 17'h00008;
    localparam logic [16:0] A_ADD    = 17'h00010;
    localparam logic [16:0] A_SUB    = 17'h00030;
    localparam logic [16:0] A_SLT    = 17'h00038;
    localparam logic [16:0] E_JAL    = 17'h00004;
    localparam logic [16:0] E_JW     = 17'h00002;
    localparam logic [16:0] E_HALT   = 17'h00001;
    localparam logic [16:0] E_ZERO   = 17'h00000;

    typedef struct {
        logic [16:0] v;
        string       n;
    } exp_t;

    logic  clk = 1'b0;
    logic  init;
    exp_t  q[$];
    exp_t  m_e;
    logic [16:0] act;
    int    total = 0;
    int    bad   = 0;

    pipe_controller_if bus ();

    pipe_controller #(
        .FLUSH_CYCLES (4),
        .DRAIN_CYCLES (3)
    ) dut (
        .clk  (clk),
        .init (init),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    assign act = {bus.PCinit, bus.PCsrc, bus.jsel, bus.clr, bus.RegDst, bus.ALUsrc,
                  bus.MemRead, bus.MemWrite, bus.MemtoReg, bus.RegWrite,
                  bus.ALUoperation, bus.jal, bus.jal_write, bus.halted};

    always @(negedge clk) begin
        if (q.size() > 0) begin
            m_e = q.pop_front();
            total++;
            if (act !== m_e.v) begin
                bad++;
                $display("FAIL %s: got %05h expected %05h", m_e.n, act, m_e.v);
            end
        end
    end

    task automatic step(input logic [5:0] op, input logic [5:0] fn, input logic e,
                        input logic st, input logic [16:0] ev, input string nm);
        exp_t x;
        bus.opcode   = op;
        bus.func     = fn;
        bus.eq       = e;
        bus.id_stall = st;
        x.v = ev;
        x.n = nm;
        q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    initial begin
        init         = 1'b1;
        bus.opcode   = 6'b000000;
        bus.func     = 6'b000000;
        bus.eq       = 1'b0;
        bus.id_stall = 1'b0;
        @(posedge clk);
        #1;
        step(6'h00, 6'h00, 1'b0, 1'b0, E_PCINIT | E_CLR, "reset_a");
        init = 1'b0;
        step(6'h00, 6'h00, 1'b0, 1'b0, E_PCINIT | E_CLR, "reset_b");
        for (int i = 0; i < 4; i++)
            step(6'b100011, 6'h00, 1'b0, 1'b0, E_CLR, "flush");

        step(6'b000000, 6'b000000, 1'b0, 1'b0, E_ZERO, "run_nop");
        step(6'b000000, 6'b100000, 1'b0, 1'b0, E_RW | A_ADD, "add");
        step(6'b000000, 6'b100010, 1'b0, 1'b0, E_RW | A_SUB, "sub");
        step(6'b000000, 6'b100100, 1'b0, 1'b0, E_RW, "and");
        step(6'b000000, 6'b100101, 1'b0, 1'b0, E_RW | A_OR, "or");
        step(6'b000000, 6'b101010, 1'b0, 1'b0, E_RW | A_SLT, "slt");
        step(6'b001000, 6'b000000, 1'b0, 1'b0, E_RW | E_RD | E_AS | A_ADD, "addi");
        step(6'b001010, 6'b000000, 1'b0, 1'b0, E_RW | E_RD | E_AS | A_SLT, "slti");
        step(6'b100011, 6'b000000, 1'b0, 1'b0,
             E_MR | E_M2R | E_RW | E_RD | E_AS | A_ADD, "lw");
        step(6'b101011, 6'b000000, 1'b0, 1'b0, E_MW | E_AS | A_ADD, "sw");
        step(6'b010101, 6'b100000, 1'b0, 1'b0, E_ZERO, "bad_opcode");
        step(6'b000100, 6'b000000, 1'b1, 1'b0, E_PCSRC | E_CLR, "beq_taken");
        step(6'b000100, 6'b000000, 1'b0, 1'b0, E_ZERO, "beq_not_taken");
        step(6'b000101, 6'b000000, 1'b1, 1'b0, E_ZERO, "bne_not_taken");
        step(6'b000101, 6'b000000, 1'b0, 1'b0, E_PCSRC | E_CLR, "bne_taken");
        step(6'b000010, 6'b000000, 1'b0, 1'b0, E_PCSRC | E_J01 | E_CLR, "j");
        step(6'b000100, 6'b000000, 1'b1, 1'b1, E_ZERO, "beq_stalled");
        step(6'b000100, 6'b000000, 1'b1, 1'b0, E_PCSRC | E_CLR, "beq_after_stall");

`ifdef PIPE_CTRL_LINK_EN
        step(6'b000000, 6'b001000, 1'b0, 1'b0, E_PCSRC | E_J10 | E_CLR, "jr");
        step(6'b000011, 6'b000000, 1'b0, 1'b1, E_RW | E_J01, "jal_stalled");
        step(6'b000011, 6'b000000, 1'b0, 1'b0, E_RW | E_PCSRC | E_J01 | E_CLR, "jal_id");
        step(6'b000000, 6'b000000, 1'b0, 1'b0, E_JAL, "jal_ex");
        step(6'b000000, 6'b000000, 1'b0, 1'b0, E_ZERO, "jal_mem");
        step(6'b000000, 6'b000000, 1'b0, 1'b0, E_JW, "jal_wb");
        step(6'b000000, 6'b000000, 1'b0, 1'b0, E_ZERO, "jal_done");
`else
        step(6'b000000, 6'b001000, 1'b0, 1'b0, E_ZERO, "jr_off");
        step(6'b000011, 6'b000000, 1'b0, 1'b1, E_ZERO, "jal_off_stalled");
        step(6'b000011, 6'b000000, 1'b0, 1'b0, E_ZERO, "jal_off_id");
        step(6'b000000, 6'b000000, 1'b0, 1'b0, E_ZERO, "jal_off_ex");
        step(6'b000000, 6'b000000, 1'b0, 1'b0, E_ZERO, "jal_off_mem");
        step(6'b000000, 6'b000000, 1'b0, 1'b0, E_ZERO, "jal_off_wb");
`endif

        step(6'b111111, 6'b000000, 1'b0, 1'b1, E_ZERO, "halt_stalled");
        step(6'b111111, 6'b000000, 1'b0, 1'b0, E_ZERO, "halt_id");
        step(6'b000000, 6'b100000, 1'b0, 1'b0, E_CLR, "drain_1");
        step(6'b100011, 6'b000000, 1'b0, 1'b0, E_CLR, "drain_2");
        step(6'b000010, 6'b000000, 1'b0, 1'b0, E_CLR, "drain_3");
        step(6'b000000, 6'b100000, 1'b0, 1'b0, E_CLR | E_HALT, "halted");
        step(6'b000100, 6'b000000, 1'b1, 1'b0, E_CLR | E_HALT, "halted_hold");
        init = 1'b1;
        step(6'b000000, 6'b000000, 1'b0, 1'b0, E_CLR | E_HALT, "halt_init_edge");
        step(6'b000000, 6'b000000, 1'b0, 1'b0, E_PCINIT | E_CLR, "reinit");

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
